// File: rtl/instr_loader_pkg.sv
// Shared CPU package: opcode constants, loader FSM encoding and the default
// program terminator word.
package instr_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned OPC_W  = 6;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OPC_J     = 6'h02;
    localparam logic [OPC_W-1:0] OPC_JAL   = 6'h03;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OPC_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// Big-endian byte-to-word shift register; flags the byte that completes a word.
module byte_assembler
    import instr_loader_pkg::*;
#(
    parameter int unsigned NBITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              valid_i,
    output logic [NBITS-1:0]  word_o,
    output logic              word_ready_c
);

    localparam int unsigned NBYTES = NBITS / BYTE_W;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [NBITS-1:0] word_q, word_d;
    logic             last_c;

    assign last_c       = (idx_q == IDX_W'(NBYTES - 1));
    assign word_ready_c = valid_i && !clear_i && last_c;
    assign word_o       = word_q;

    // First byte of a word ends up in the most significant lane.
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (valid_i) begin
            word_d = {word_q[NBITS-BYTE_W-1:0], byte_i};
            idx_d  = last_c ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Serial program loader: assembles bytes into words, writes them into the
// instruction memory and holds the CPU in reset until the load finishes.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned      NBITS     = 32,
    parameter int unsigned      ABITS     = 8,
    parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [BYTE_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_mem_we,
    output logic [ABITS-1:0]  o_mem_addr,
    output logic [NBITS-1:0]  o_mem_data,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic [ABITS:0]    o_word_count,
    output logic              o_overflow
);

    localparam logic [ABITS:0] CELDAS = (ABITS + 1)'(1 << ABITS);

    loader_state_e    state_q, state_d;
    logic [ABITS:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             rx_ready_q, mem_we_q, hold_q, done_q;
    logic             asm_clear_c;
    logic             accept_c;
    logic             word_ready_c;
    logic [NBITS-1:0] asm_word;

    assign accept_c = i_rx_valid && rx_ready_q;

    byte_assembler #(
        .NBITS (NBITS)
    ) u_asm (
        .clk          (i_clk),
        .rst_n        (i_reset),
        .clear_i      (asm_clear_c),
        .byte_i       (i_rx_data),
        .valid_i      (accept_c),
        .word_o       (asm_word),
        .word_ready_c (word_ready_c)
    );

    // Next-state logic; count and overflow only change on load start or WRITE exit.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        asm_clear_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d     = ST_RECV;
                    count_d     = '0;
                    ovf_d       = 1'b0;
                    asm_clear_c = 1'b1;
                end
            end
            ST_RECV: begin
                if (word_ready_c) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                count_d = count_q + (ABITS + 1)'(1);
                if (asm_word == HALT_WORD) begin
                    state_d = ST_DONE;
                end else if (count_d == CELDAS) begin
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so each one comes straight off a flop.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rx_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            rx_ready_q <= (state_d == ST_RECV);
            mem_we_q   <= (state_d == ST_WRITE);
            hold_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign o_rx_ready   = rx_ready_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = count_q[ABITS-1:0];
    assign o_mem_data   = asm_word;
    assign o_cpu_hold   = hold_q;
    assign o_done       = done_q;
    assign o_word_count = count_q;
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a 256-word and a 4-word instance, with a
// write scoreboard per instance.
module tb_instr_loader;

    logic clk = 1'b0;
    logic rst_n;

    logic        start8, valid8, ready8, we8, hold8, done8, ovf8;
    logic [7:0]  data8, addr8;
    logic [31:0] mdata8;
    logic [8:0]  cnt8;

    logic        start2, valid2, ready2, we2, hold2, done2, ovf2;
    logic [7:0]  data2;
    logic [1:0]  addr2;
    logic [31:0] mdata2;
    logic [2:0]  cnt2;

    int checks   = 0;
    int failures = 0;
    int exp_cnt8 = 0;
    int exp_cnt2 = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t q8[$];
    wr_t q2[$];

    always #5 clk = ~clk;

    instr_loader #(.NBITS(32), .ABITS(8)) dut8 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start8), .i_rx_data(data8),
        .i_rx_valid(valid8), .o_rx_ready(ready8), .o_mem_we(we8),
        .o_mem_addr(addr8), .o_mem_data(mdata8), .o_cpu_hold(hold8),
        .o_done(done8), .o_word_count(cnt8), .o_overflow(ovf8)
    );

    instr_loader #(.NBITS(32), .ABITS(2)) dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start2), .i_rx_data(data2),
        .i_rx_valid(valid2), .o_rx_ready(ready2), .o_mem_we(we2),
        .o_mem_addr(addr2), .o_mem_data(mdata2), .o_cpu_hold(hold2),
        .o_done(done2), .o_word_count(cnt2), .o_overflow(ovf2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write scoreboard: every strobe must match the oldest pushed word.
    always @(negedge clk) begin
        wr_t e;
        if (we8 === 1'b1) begin
            chk("wr8_expected", 64'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                chk("wr8_addr", 64'(addr8), 64'(e.addr));
                chk("wr8_data", 64'(mdata8), 64'(e.data));
            end
        end
        if (we2 === 1'b1) begin
            chk("wr2_expected", 64'(q2.size() != 0), 1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("wr2_addr", 64'(addr2), 64'(e.addr));
                chk("wr2_data", 64'(mdata2), 64'(e.data));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input bit s);
        if (s) start2 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic send_byte(input bit s, input logic [7:0] b);
        int n = 0;
        if (s) begin valid2 = 1'b1; data2 = b; end
        else   begin valid8 = 1'b1; data8 = b; end
        while (((s ? ready2 : ready8) !== 1'b1) && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("rx_ready_wait", 64'(n < 64), 1);
        @(negedge clk);
        if (s) valid2 = 1'b0; else valid8 = 1'b0;
    endtask

    task automatic send_word(input bit s, input logic [31:0] w);
        wr_t e;
        e.data = w;
        if (s) begin
            e.addr = 8'(exp_cnt2 % 4);
            q2.push_back(e);
            exp_cnt2++;
        end else begin
            e.addr = 8'(exp_cnt8);
            q8.push_back(e);
            exp_cnt8++;
        end
        for (int i = 0; i < 4; i++) send_byte(s, w[31-8*i -: 8]);
    endtask

    initial begin
        logic [31:0] w;
        wr_t e;
        rst_n = 1'b0;
        start8 = 1'b0; valid8 = 1'b0; data8 = 8'h00;
        start2 = 1'b0; valid2 = 1'b0; data2 = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", 64'(ready8), 0);
        chk("rst_we", 64'(we8), 0);
        chk("rst_hold", 64'(hold8), 0);
        chk("rst_done", 64'(done8), 0);
        chk("rst_count", 64'(cnt8), 0);
        chk("rst_ovf", 64'(ovf8), 0);
        chk("rst_addr", 64'(addr8), 0);
        chk("rst_data", 64'(mdata8), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_hold", 64'(hold8), 0);

        // Normal load: one instruction then HALT
        pulse_start(0);
        chk("recv_ready", 64'(ready8), 1);
        chk("recv_hold", 64'(hold8), 1);
        chk("recv_count", 64'(cnt8), 0);
        send_word(0, 32'h2008_0005);
        chk("write_ready_low", 64'(ready8), 0);
        chk("write_count_old", 64'(cnt8), 0);
        send_word(0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("n_done", 64'(done8), 1);
        chk("n_count", 64'(cnt8), 2);
        chk("n_ovf", 64'(ovf8), 0);
        chk("n_hold_done", 64'(hold8), 1);
        @(negedge clk);
        chk("n_done_pulse", 64'(done8), 0);
        chk("n_release", 64'(hold8), 0);
        chk("n_count_kept", 64'(cnt8), 2);

        // Backpressure during WRITE plus ignored start pulses
        exp_cnt8 = 0;
        pulse_start(0);
        chk("bp_count_clr", 64'(cnt8), 0);
        send_word(0, 32'h1122_3344);
        valid8 = 1'b1; data8 = 8'hAA; start8 = 1'b1;
        chk("bp_ready_low", 64'(ready8), 0);
        chk("bp_we", 64'(we8), 1);
        @(negedge clk);
        start8 = 1'b0;
        chk("bp_count_after", 64'(cnt8), 1);
        e.addr = 8'(exp_cnt8); e.data = 32'hAABB_CCDD;
        q8.push_back(e);
        exp_cnt8++;
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        pulse_start(0);
        chk("st_count", 64'(cnt8), 1);
        chk("st_ready", 64'(ready8), 1);
        send_byte(0, 8'hCC);
        send_byte(0, 8'hDD);
        @(negedge clk);
        chk("bp_sb_empty", 64'(q8.size()), 0);
        send_word(0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("bp_done", 64'(done8), 1);
        chk("bp_count", 64'(cnt8), 3);
        @(negedge clk);

        // Reset mid-load after six bytes
        exp_cnt8 = 0;
        pulse_start(0);
        send_word(0, 32'hDEAD_BEEF);
        send_byte(0, 8'h12);
        send_byte(0, 8'h34);
        rst_n = 1'b0;
        #1;
        chk("mr_hold", 64'(hold8), 0);
        chk("mr_ready", 64'(ready8), 0);
        chk("mr_we", 64'(we8), 0);
        chk("mr_count", 64'(cnt8), 0);
        chk("mr_data", 64'(mdata8), 0);
        @(negedge clk);
        rst_n = 1'b1;
        valid8 = 1'b1; data8 = 8'h56;
        repeat (3) @(negedge clk);
        chk("mr_no_start_ready", 64'(ready8), 0);
        chk("mr_no_start_hold", 64'(hold8), 0);
        valid8 = 1'b0;
        exp_cnt8 = 0;
        pulse_start(0);
        send_word(0, 32'h0102_0304);
        send_word(0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("mr_reload_done", 64'(done8), 1);
        chk("mr_reload_count", 64'(cnt8), 2);
        @(negedge clk);

        // Overflow: four non-halt words fill the 4-word memory
        pulse_start(1);
        for (int i = 0; i < 4; i++) begin
            w = 32'h1000_0000 + 32'(i);
            send_word(1, w);
        end
        @(negedge clk);
        chk("of_done", 64'(done2), 1);
        chk("of_ovf", 64'(ovf2), 1);
        chk("of_count", 64'(cnt2), 4);
        @(negedge clk);
        chk("of_release", 64'(hold2), 0);
        chk("of_sticky", 64'(ovf2), 1);
        chk("of_ready_idle", 64'(ready2), 0);

        // HALT in the last cell completes without overflow
        exp_cnt2 = 0;
        pulse_start(1);
        chk("lc_ovf_clr", 64'(ovf2), 0);
        chk("lc_count_clr", 64'(cnt2), 0);
        for (int i = 0; i < 3; i++) begin
            w = 32'hA0B0_C000 + 32'(i);
            send_word(1, w);
        end
        send_word(1, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("lc_done", 64'(done2), 1);
        chk("lc_ovf", 64'(ovf2), 0);
        chk("lc_count", 64'(cnt2), 4);
        @(negedge clk);
        chk("lc_release", 64'(hold2), 0);

        repeat (2) @(negedge clk);
        chk("sb8_drained", 64'(q8.size()), 0);
        chk("sb2_drained", 64'(q2.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
